// File: rtl/calc_issue_unit.sv
// Front end for a fixed-latency 8x8->16 calculator core. Commands are queued, issued under
// credit control, and their results are returned in order with the tag and a div-by-zero flag.
module calc_issue_unit #(
    parameter int LATENCY   = 2,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_func,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       calc_func,
    output logic [7:0]       calc_a,
    output logic [7:0]       calc_b,
    input  logic [15:0]      calc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_div0,
    output logic             busy
);
    localparam int CP_W = $clog2(CMD_DEPTH);
    localparam int RI_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int RC_W = $clog2(RES_DEPTH + 1);
    localparam int IF_W = $clog2(LATENCY + 2);
    localparam int CR_W = $clog2(LATENCY + RES_DEPTH + 3);

    typedef struct packed {
        logic [1:0]       func;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
        logic             div0;
    } cmd_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             div0;
    } token_t;

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             div0;
    } res_t;

    cmd_t            cmd_mem [CMD_DEPTH];
    logic [CP_W:0]   cmd_wr, cmd_rd, cmd_wr_next, cmd_rd_next;
    cmd_t            cmd_head;
    logic            cmd_empty, cmd_full_next, push, issue;

    token_t          pipe [LATENCY+1];
    logic            capture;
    logic [IF_W-1:0] inflight;
    logic [CR_W-1:0] credit_used;

    res_t            res_mem [RES_DEPTH];
    logic [RI_W-1:0] res_wr, res_rd;
    logic [RC_W-1:0] res_count;
    logic            pop;
    res_t            res_head;

    function automatic logic [RI_W-1:0] res_inc(input logic [RI_W-1:0] p);
        return (p == RI_W'(RES_DEPTH - 1)) ? '0 : p + RI_W'(1);
    endfunction

    assign push      = cmd_valid && cmd_ready;
    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_head  = cmd_mem[cmd_rd[CP_W-1:0]];
    assign capture   = pipe[LATENCY].valid;
    assign res_valid = (res_count != '0);
    assign pop       = res_valid && res_ready;
    assign res_head  = res_mem[res_rd];

    always_comb begin
        // NOTE: the default comes first so every path assigns and no latch is inferred.
        inflight = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            inflight = inflight + IF_W'(pipe[i].valid);
        end
    end

    // A result leaving at this edge frees its slot now, so a full stream needs no bubble.
    assign credit_used = CR_W'(inflight) + CR_W'(res_count) - CR_W'(pop);
    assign issue       = !cmd_empty && (credit_used < CR_W'(RES_DEPTH));

    assign cmd_wr_next   = cmd_wr + (CP_W + 1)'(push);
    assign cmd_rd_next   = cmd_rd + (CP_W + 1)'(issue);
    assign cmd_full_next = (cmd_wr_next[CP_W] != cmd_rd_next[CP_W]) &&
                           (cmd_wr_next[CP_W-1:0] == cmd_rd_next[CP_W-1:0]);

    assign busy     = !cmd_empty || (inflight != '0) || res_valid;
    assign res_data = res_valid ? res_head.data : '0;
    assign res_tag  = res_valid ? res_head.tag  : '0;
    assign res_div0 = res_valid ? res_head.div0 : 1'b0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cmd_wr    <= '0;
            cmd_rd    <= '0;
            cmd_ready <= 1'b0;
            calc_func <= '0;
            calc_a    <= '0;
            calc_b    <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                pipe[i] <= '0;
            end
            res_wr    <= '0;
            res_rd    <= '0;
            res_count <= '0;
        end else begin
            cmd_wr    <= cmd_wr_next;
            cmd_rd    <= cmd_rd_next;
            cmd_ready <= !cmd_full_next;
            if (issue) begin
                calc_func <= cmd_head.func;
                calc_a    <= cmd_head.a;
                calc_b    <= cmd_head.b;
            end
            pipe[0] <= token_t'{valid: issue, tag: cmd_head.tag, div0: cmd_head.div0};
            for (int i = 1; i <= LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (capture) res_wr <= res_inc(res_wr);
            if (pop)     res_rd <= res_inc(res_rd);
            res_count <= res_count + RC_W'(capture) - RC_W'(pop);
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[cmd_wr[CP_W-1:0]] <= cmd_t'{func: cmd_func, a: cmd_a, b: cmd_b, tag: cmd_tag,
                                                div0: (cmd_func == 2'b11) && (cmd_b == 8'd0)};
        end
        if (capture) begin
            res_mem[res_wr] <= res_t'{data: calc_out, tag: pipe[LATENCY].tag, div0: pipe[LATENCY].div0};
        end
    end

    // Credit gating must keep a capture from ever landing on a full result buffer.
    result_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && !pop && (res_count == RC_W'(RES_DEPTH))));

endmodule

// File: tb/tb_calc_issue_unit.sv
// Self-checking bench for calc_issue_unit: behavioural core stub, in-order scoreboard driven
// by observed handshakes, and scenario tasks for latency, backpressure, streaming and reset.
module tb_calc_issue_unit;
    localparam int LATENCY   = 2;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_func = '0;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [1:0]       calc_func;
    logic [7:0]       calc_a;
    logic [7:0]       calc_b;
    logic [15:0]      calc_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_div0;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    always #5 clk = ~clk;

    calc_issue_unit #(
        .LATENCY(LATENCY), .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .calc_func(calc_func), .calc_a(calc_a), .calc_b(calc_b), .calc_out(calc_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_div0(res_div0), .busy(busy)
    );

    // Arithmetic of the calculator, straight from the operation table.
    function automatic logic [15:0] ref_calc(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (f)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            2'b10:   r = sa * sb;
            default: r = (sb == 0) ? ((sa >= 0) ? 32'sh7FFF : -32768) : sa / sb;
        endcase
        return r[15:0];
    endfunction

    // Core stand-in: operands sampled at edge k appear on calc_out for sampling at edge k+LATENCY.
    logic [15:0] core_q [LATENCY];
    always @(posedge clk) begin
        core_q[0] <= ref_calc(calc_func, calc_a, calc_b);
        for (int i = 1; i < LATENCY; i++) core_q[i] <= core_q[i-1];
    end
    assign calc_out = core_q[LATENCY-1];

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             div0;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_head;

    // Scoreboard: every accepted command expects exactly one result, in acceptance order.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready)
                exp_q.push_back(exp_t'{data: ref_calc(cmd_func, cmd_a, cmd_b), tag: cmd_tag,
                                       div0: (cmd_func == 2'b11) && (cmd_b == 8'd0)});
            if (res_valid && res_ready) begin
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data %h tag %0d div0 %0d, required no result",
                             res_data, res_tag, res_div0);
                end else begin
                    sb_head = exp_q.pop_front();
                    if ({res_data, res_tag, res_div0} !== sb_head) begin
                        errors++;
                        $display("FAIL sb_result: got data %h tag %0d div0 %0d, required data %h tag %0d div0 %0d",
                                 res_data, res_tag, res_div0, sb_head.data, sb_head.tag, sb_head.div0);
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                            input logic [TAG_W-1:0] t);
        bit done = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; cmd_tag = t;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            done = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for tag %0d, required 1", t);
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge clk);
            idle = !busy;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s_idle: busy=1 after 300 cycles, required 0", name);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_lost: %0d results outstanding when idle, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, res_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: cmd_ready/res_valid/busy=%b, required 000", {cmd_ready, res_valid, busy});
        end
        checks++;
        if ({res_data, res_tag, res_div0} !== '0) begin
            errors++;
            $display("FAIL reset_result: data %h tag %0d div0 %0d, required all 0", res_data, res_tag, res_div0);
        end
        checks++;
        if ({calc_func, calc_a, calc_b} !== '0) begin
            errors++;
            $display("FAIL reset_calc: func %b a %h b %h, required all 0", calc_func, calc_a, calc_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: cmd_ready=%b before first edge out of reset, required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_rise: cmd_ready=%b busy=%b, required 1 and 0", cmd_ready, busy);
        end
    endtask

    task automatic run_directed(input string name, input logic [1:0] f, input logic [7:0] a,
                                input logic [7:0] b, input logic [TAG_W-1:0] t,
                                input logic [15:0] want_data, input logic want_div0);
        int n = 0;
        res_ready = 1'b1;
        push_cmd(f, a, b, t);
        while (n < 20) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk);
            n++;
        end
        checks++;
        if (n != LATENCY + 2) begin
            errors++;
            $display("FAIL %s_latency: res_valid after %0d edges, required %0d", name, n, LATENCY + 2);
        end
        checks++;
        if (res_data !== want_data || res_tag !== t || res_div0 !== want_div0) begin
            errors++;
            $display("FAIL %s_value: data %h tag %0d div0 %0d, required data %h tag %0d div0 %0d",
                     name, res_data, res_tag, res_div0, want_data, t, want_div0);
        end
        wait_idle(name);
    endtask

    task automatic test_directed();
        run_directed("add",      2'b00, 8'd5,   8'd3, 4'd1, 16'd8,     1'b0);
        run_directed("mul_neg",  2'b10, 8'hFD,  8'd7, 4'd2, 16'hFFEB,  1'b0);
        run_directed("div0_pos", 2'b11, 8'h05,  8'd0, 4'd3, 16'h7FFF,  1'b1);
        run_directed("div0_neg", 2'b11, 8'hF0,  8'd0, 4'd4, 16'h8000,  1'b1);
        run_directed("sub",      2'b01, 8'h80,  8'd1, 4'd5, 16'hFF7F,  1'b0);
        run_directed("div",      2'b11, 8'hF9,  8'd2, 4'd6, 16'hFFFD,  1'b0);
    endtask

    task automatic test_backpressure();
        int  p0 = pops;
        bit  stalled = 1'b1;
        res_ready = 1'b0;
        for (int t = 0; t < CMD_DEPTH + RES_DEPTH; t++)
            push_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), TAG_W'(t));
        cmd_valid = 1'b1; cmd_func = 2'b00; cmd_a = 8'd1; cmd_b = 8'd2;
        cmd_tag = TAG_W'(CMD_DEPTH + RES_DEPTH);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (cmd_ready) stalled = 1'b0;
        end
        checks++;
        if (!stalled) begin
            errors++;
            $display("FAIL bp_ready: cmd_ready rose with both buffers full, required 0");
        end
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_state: res_valid=%b busy=%b, required 1 and 1", res_valid, busy);
        end
        checks++;
        if (exp_q.size() != CMD_DEPTH + RES_DEPTH || pops != p0) begin
            errors++;
            $display("FAIL bp_accepted: accepted %0d popped %0d, required %0d and 0",
                     exp_q.size(), pops - p0, CMD_DEPTH + RES_DEPTH);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int t = CMD_DEPTH + RES_DEPTH; t < 10; t++)
            push_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), TAG_W'(t));
        wait_idle("bp");
        checks++;
        if (pops - p0 != 10) begin
            errors++;
            $display("FAIL bp_count: %0d results returned, required 10", pops - p0);
        end
    endtask

    task automatic test_streaming();
        localparam int N = 32;
        int idx = 0, got = 0, first = -1, last = -1, stalls = 0;
        bit acc;
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_func = 2'($urandom_range(0, 3));
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = TAG_W'(idx);
        for (int n = 0; n < 300 && got < N; n++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            if (cmd_valid && !cmd_ready) stalls++;
            if (res_valid && res_ready) begin
                got++;
                if (first < 0) first = n;
                last = n;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < N) begin
                    cmd_func = 2'($urandom_range(0, 3));
                    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = TAG_W'(idx);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (got != N || last - first != N - 1) begin
            errors++;
            $display("FAIL stream_rate: %0d results over %0d cycles, required %0d over %0d",
                     got, last - first + 1, N, N);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL stream_ready: cmd_ready low for %0d cycles, required 0", stalls);
        end
        wait_idle("stream");
    endtask

    task automatic test_random();
        bit acc;
        int p0 = pops;
        int pushed = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            if (acc) pushed++;
            @(posedge clk); #1;
            if (acc || !cmd_valid) begin
                cmd_valid = ($urandom_range(0, 9) < 7);
                cmd_func  = 2'($urandom_range(0, 3));
                cmd_a     = 8'($urandom);
                cmd_b     = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                cmd_tag   = TAG_W'($urandom);
            end
            res_ready = 1'($urandom_range(0, 1));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle("random");
        checks++;
        if (pops - p0 != pushed) begin
            errors++;
            $display("FAIL random_count: %0d results for %0d commands", pops - p0, pushed);
        end
    endtask

    task automatic test_reset_midop();
        int p0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_func = 2'b00; cmd_a = 8'd10; cmd_b = 8'd20; cmd_tag = 4'd7;
        @(posedge clk); #1;
        cmd_func = 2'b01; cmd_tag = 4'd8;
        @(posedge clk); #1;
        cmd_func = 2'b10; cmd_tag = 4'd9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_before: res_valid=%b busy=%b, required 1 and 1", res_valid, busy);
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: res_valid=%b busy=%b, required 0 and 0", res_valid, busy);
        end
        p0 = pops;
        res_ready = 1'b1;
        push_cmd(2'b10, 8'hF6, 8'd3, 4'd12);
        wait_idle("midop");
        repeat (6) @(negedge clk);
        checks++;
        if (pops - p0 != 1) begin
            errors++;
            $display("FAIL midop_count: %0d results after reset, required 1", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
